// File: rtl/src_pkg.sv
`default_nettype none
// ============================================================================
// Package  : src_pkg
// Shared word width, PC reset default and bus-source encoding for the
// Mini-SRC datapath.
// Revision : 1.0
// ============================================================================
package src_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] PC_RESET_DEF = 32'h0;

    // Bus source after priority resolution of the out-enables
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_PC   = 3'd1,
        SEL_ZLO  = 3'd2,
        SEL_ZHI  = 3'd3,
        SEL_MDR  = 3'd4,
        SEL_R2   = 3'd5,
        SEL_R3   = 3'd6
    } bus_sel_e;

endpackage
`default_nettype wire

// File: rtl/src_reg32.sv
`default_nettype none
// ============================================================================
// Module   : src_reg32
// Load-enable register with asynchronous active-low clear to RESET_VAL.
// Revision : 1.0
// ============================================================================
module src_reg32
    import src_pkg::*;
#(
    parameter int               WIDTH     = WORD_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    assign data_d = en_i ? d_i : data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/src_datapath.sv
`default_nettype none
// ============================================================================
// Module   : src_datapath
// Mini-SRC single-bus datapath: registers, bus mux and ALU, sequenced by
// external one-hot strobes. Define MUL_EN to include the signed multiplier.
// Revision : 1.0
// ============================================================================
module src_datapath
    import src_pkg::*;
#(
    parameter int               WIDTH    = WORD_W,
    parameter logic [WIDTH-1:0] PC_RESET = PC_RESET_DEF
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             Zhighout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             LOin,
    input  logic             HIin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             MUL,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic [WIDTH-1:0] Mdatain
);

    logic [WIDTH-1:0]   bus;
    logic [WIDTH-1:0]   R1;
    logic [WIDTH-1:0]   R2;
    logic [WIDTH-1:0]   R3;
    logic [WIDTH-1:0]   PC;
    logic [WIDTH-1:0]   IR;
    logic [WIDTH-1:0]   MAR;
    logic [WIDTH-1:0]   MDR;
    logic [WIDTH-1:0]   Y;
    logic [WIDTH-1:0]   Zhigh;
    logic [WIDTH-1:0]   Zlow;
    logic [WIDTH-1:0]   HI;
    logic [WIDTH-1:0]   LO;

    bus_sel_e           bus_sel;
    logic [2*WIDTH-1:0] alu_c;
    logic [WIDTH-1:0]   pc_d;
    logic [WIDTH-1:0]   mdr_d;
    logic               pc_en;

    // ------------------------------------------------------------------
    // Bus: out-enables resolved by fixed priority, then a plain mux
    // ------------------------------------------------------------------
    always_comb begin
        bus_sel = SEL_NONE;
        if (PCout) begin
            bus_sel = SEL_PC;
        end else if (Zlowout) begin
            bus_sel = SEL_ZLO;
        end else if (Zhighout) begin
            bus_sel = SEL_ZHI;
        end else if (MDRout) begin
            bus_sel = SEL_MDR;
        end else if (R2out) begin
            bus_sel = SEL_R2;
        end else if (R3out) begin
            bus_sel = SEL_R3;
        end
    end

    always_comb begin
        bus = '0;
        case (bus_sel)
            SEL_PC:  bus = PC;
            SEL_ZLO: bus = Zlow;
            SEL_ZHI: bus = Zhigh;
            SEL_MDR: bus = MDR;
            SEL_R2:  bus = R2;
            SEL_R3:  bus = R3;
            default: bus = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
`ifdef MUL_EN
    logic signed [2*WIDTH-1:0] y_ext;
    logic signed [2*WIDTH-1:0] bus_ext;

    // Operands sign-extended so the low 2*WIDTH product bits are exact
    assign y_ext   = {{WIDTH{Y[WIDTH-1]}}, Y};
    assign bus_ext = {{WIDTH{bus[WIDTH-1]}}, bus};
    assign alu_c   = MUL ? (y_ext * bus_ext) : {{WIDTH{1'b0}}, bus};
`else
    logic unused_alu;

    assign alu_c      = {{WIDTH{1'b0}}, bus};
    assign unused_alu = ^{MUL, Y};
`endif

    // ------------------------------------------------------------------
    // Register next-state selects
    // ------------------------------------------------------------------
    assign pc_en = IncPC | PCin;
    assign pc_d  = IncPC ? (PC + WIDTH'(1)) : bus;
    assign mdr_d = Read ? Mdatain : bus;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    src_reg32 #(.WIDTH(WIDTH), .RESET_VAL(PC_RESET)) u_pc (
        .clk_i (Clock), .rst_ni(clear), .en_i(pc_en), .d_i(pc_d), .q_o(PC)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_r1 (
        .clk_i (Clock), .rst_ni(clear), .en_i(R1in), .d_i(bus), .q_o(R1)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_r2 (
        .clk_i (Clock), .rst_ni(clear), .en_i(R2in), .d_i(bus), .q_o(R2)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_r3 (
        .clk_i (Clock), .rst_ni(clear), .en_i(R3in), .d_i(bus), .q_o(R3)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_ir (
        .clk_i (Clock), .rst_ni(clear), .en_i(IRin), .d_i(bus), .q_o(IR)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_mar (
        .clk_i (Clock), .rst_ni(clear), .en_i(MARin), .d_i(bus), .q_o(MAR)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_mdr (
        .clk_i (Clock), .rst_ni(clear), .en_i(MDRin), .d_i(mdr_d), .q_o(MDR)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_y (
        .clk_i (Clock), .rst_ni(clear), .en_i(Yin), .d_i(bus), .q_o(Y)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_zhigh (
        .clk_i (Clock), .rst_ni(clear), .en_i(Zin), .d_i(alu_c[2*WIDTH-1:WIDTH]), .q_o(Zhigh)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_zlow (
        .clk_i (Clock), .rst_ni(clear), .en_i(Zin), .d_i(alu_c[WIDTH-1:0]), .q_o(Zlow)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_hi (
        .clk_i (Clock), .rst_ni(clear), .en_i(HIin), .d_i(bus), .q_o(HI)
    );

    src_reg32 #(.WIDTH(WIDTH)) u_lo (
        .clk_i (Clock), .rst_ni(clear), .en_i(LOin), .d_i(bus), .q_o(LO)
    );

    // These registers are observed hierarchically only; nothing here reads them
    logic unused_probe;
    assign unused_probe = ^{R1, IR, MAR, HI, LO};

endmodule
`default_nettype wire

// File: tb/tb_src_datapath.sv
`default_nettype none
// Randomised scoreboard bench for src_datapath; expectations come from a
// register-array reference model and are checked at the falling edge.
module tb_src_datapath;

    localparam int ID_R1  = 0;
    localparam int ID_R2  = 1;
    localparam int ID_R3  = 2;
    localparam int ID_PC  = 3;
    localparam int ID_IR  = 4;
    localparam int ID_MAR = 5;
    localparam int ID_MDR = 6;
    localparam int ID_Y   = 7;
    localparam int ID_ZH  = 8;
    localparam int ID_ZL  = 9;
    localparam int ID_HI  = 10;
    localparam int ID_LO  = 11;
    localparam int ID_BUS = 12;
    localparam int NREG   = 12;
    localparam logic [31:0] PCR = 32'h0;

    typedef struct packed {
        bit PCout, Zlowout, Zhighout, MDRout, R2out, R3out;
        bit MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
        bit IncPC, Read, MUL, R1in, R2in, R3in;
    } ctrl_t;

    typedef struct {
        int          cyc;
        int          id;
        logic [31:0] exp;
    } exp_t;

    logic        Clock = 1'b0;
    logic        clear = 1'b0;
    logic        PCout = 0, Zlowout = 0, Zhighout = 0, MDRout = 0, R2out = 0, R3out = 0;
    logic        MARin = 0, Zin = 0, PCin = 0, MDRin = 0, IRin = 0, Yin = 0, LOin = 0, HIin = 0;
    logic        IncPC = 0, Read = 0, MUL = 0, R1in = 0, R2in = 0, R3in = 0;
    logic [31:0] Mdatain = '0;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [31:0] m [NREG];
    string       nm [13] = '{"R1", "R2", "R3", "PC", "IR", "MAR", "MDR", "Y",
                             "Zhigh", "Zlow", "HI", "LO", "bus"};

    src_datapath dut (
        .Clock   (Clock),   .clear   (clear),
        .PCout   (PCout),   .Zlowout (Zlowout), .Zhighout(Zhighout),
        .MDRout  (MDRout),  .R2out   (R2out),   .R3out   (R3out),
        .MARin   (MARin),   .Zin     (Zin),     .PCin    (PCin),
        .MDRin   (MDRin),   .IRin    (IRin),    .Yin     (Yin),
        .LOin    (LOin),    .HIin    (HIin),    .IncPC   (IncPC),
        .Read    (Read),    .MUL     (MUL),     .R1in    (R1in),
        .R2in    (R2in),    .R3in    (R3in),    .Mdatain (Mdatain)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [31:0] probe(input int id);
        case (id)
            ID_R1:   return dut.R1;
            ID_R2:   return dut.R2;
            ID_R3:   return dut.R3;
            ID_PC:   return dut.PC;
            ID_IR:   return dut.IR;
            ID_MAR:  return dut.MAR;
            ID_MDR:  return dut.MDR;
            ID_Y:    return dut.Y;
            ID_ZH:   return dut.Zhigh;
            ID_ZL:   return dut.Zlow;
            ID_HI:   return dut.HI;
            ID_LO:   return dut.LO;
            default: return dut.bus;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%08h expected=%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every expectation that has come due
    always @(negedge Clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(nm[e.id], probe(e.id), e.exp);
        end
    end

    task automatic drive(input ctrl_t c, input logic [31:0] md);
        PCout = c.PCout; Zlowout = c.Zlowout; Zhighout = c.Zhighout;
        MDRout = c.MDRout; R2out = c.R2out; R3out = c.R3out;
        MARin = c.MARin; Zin = c.Zin; PCin = c.PCin; MDRin = c.MDRin;
        IRin = c.IRin; Yin = c.Yin; LOin = c.LOin; HIin = c.HIin;
        IncPC = c.IncPC; Read = c.Read; MUL = c.MUL;
        R1in = c.R1in; R2in = c.R2in; R3in = c.R3in;
        Mdatain = md;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m[i] = 32'h0;
        m[ID_PC] = PCR;
    endtask

    // Called at posedge+1: drive one cycle, queue expectations, advance
    task automatic step(input ctrl_t c, input logic [31:0] md);
        logic [31:0] b;
        logic [63:0] z;
        logic [31:0] n [NREG];
        drive(c, md);
        b = c.PCout    ? m[ID_PC]  :
            c.Zlowout  ? m[ID_ZL]  :
            c.Zhighout ? m[ID_ZH]  :
            c.MDRout   ? m[ID_MDR] :
            c.R2out    ? m[ID_R2]  :
            c.R3out    ? m[ID_R3]  : 32'h0;
        z = {32'h0, b};
`ifdef MUL_EN
        if (c.MUL) begin
            longint ya, ba;
            ya = $signed(m[ID_Y]);
            ba = $signed(b);
            z  = ya * ba;
        end
`endif
        n = m;
        if (c.R1in)  n[ID_R1]  = b;
        if (c.R2in)  n[ID_R2]  = b;
        if (c.R3in)  n[ID_R3]  = b;
        if (c.MARin) n[ID_MAR] = b;
        if (c.IRin)  n[ID_IR]  = b;
        if (c.Yin)   n[ID_Y]   = b;
        if (c.HIin)  n[ID_HI]  = b;
        if (c.LOin)  n[ID_LO]  = b;
        if (c.MDRin) n[ID_MDR] = c.Read ? md : b;
        if (c.IncPC)     n[ID_PC] = m[ID_PC] + 32'd1;
        else if (c.PCin) n[ID_PC] = b;
        if (c.Zin) begin
            n[ID_ZH] = z[63:32];
            n[ID_ZL] = z[31:0];
        end
        sb.push_back('{cyc: cyc, id: ID_BUS, exp: b});
        for (int i = 0; i < NREG; i++) sb.push_back('{cyc: cyc + 1, id: i, exp: n[i]});
        m = n;
        @(posedge Clock);
        #1;
    endtask

    task automatic expect_now(input string name, input int id, input logic [31:0] exp);
        check(name, probe(id), exp);
    endtask

    task automatic check_all_reset(input string tag);
        for (int i = 0; i < NREG; i++)
            check({tag, "_", nm[i]}, probe(i), (i == ID_PC) ? PCR : 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ctrl_t       c;
        logic [19:0] rb;

        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        check_all_reset("rst_hold");
        clear = 1'b1;

        // Loads through MDR
        c = '0; c.Read = 1; c.MDRin = 1; step(c, 32'h12);
        expect_now("mdr_12", ID_MDR, 32'h12);
        c = '0; c.MDRout = 1; c.R2in = 1; step(c, 32'h0);
        expect_now("r2_12", ID_R2, 32'h12);
        c = '0; c.Read = 1; c.MDRin = 1; step(c, 32'h14);
        c = '0; c.MDRout = 1; c.R3in = 1; step(c, 32'h0);
        expect_now("r3_14", ID_R3, 32'h14);
        c = '0; c.Read = 1; c.MDRin = 1; step(c, 32'h04);
        c = '0; c.MDRout = 1; c.R1in = 1; step(c, 32'h0);
        expect_now("r1_04", ID_R1, 32'h04);

        // Fetch
        c = '0; c.PCout = 1; c.MARin = 1; c.Zin = 1; step(c, 32'h0);
        expect_now("t0_mar", ID_MAR, 32'h0);
        c = '0; c.Zlowout = 1; c.PCin = 1; c.IncPC = 1; c.Read = 1; c.MDRin = 1;
        step(c, 32'h6091_8000);
        expect_now("t1_pc", ID_PC, 32'h1);
        expect_now("t1_mdr", ID_MDR, 32'h6091_8000);
        c = '0; c.MDRout = 1; c.IRin = 1; step(c, 32'h0);
        expect_now("t2_ir", ID_IR, 32'h6091_8000);

        // Pass-through
        c = '0; c.R3out = 1; c.Zin = 1; step(c, 32'h0);
        expect_now("t3_zlo", ID_ZL, 32'h14);
        expect_now("t3_zhi", ID_ZH, 32'h0);
        c = '0; c.Zlowout = 1; c.R1in = 1; step(c, 32'h0);
        expect_now("t4_r1", ID_R1, 32'h14);

        // Multiply (MUL ignored when the multiplier is not built)
        c = '0; c.R2out = 1; c.Yin = 1; step(c, 32'h0);
        c = '0; c.R3out = 1; c.MUL = 1; c.Zin = 1; step(c, 32'h0);
`ifdef MUL_EN
        expect_now("mul_zlo", ID_ZL, 32'h168);
`else
        expect_now("mul_zlo", ID_ZL, 32'h14);
`endif
        expect_now("mul_zhi", ID_ZH, 32'h0);
        c = '0; c.Zlowout = 1; c.LOin = 1; step(c, 32'h0);
        c = '0; c.Zhighout = 1; c.HIin = 1; step(c, 32'h0);
        expect_now("mul_hi", ID_HI, 32'h0);
        c = '0; c.Read = 1; c.MDRin = 1; step(c, 32'hFFFF_FFFF);
        c = '0; c.MDRout = 1; c.Yin = 1; step(c, 32'h0);
        c = '0; c.R3out = 1; c.MUL = 1; c.Zin = 1; step(c, 32'h0);
`ifdef MUL_EN
        expect_now("neg_zhi", ID_ZH, 32'hFFFF_FFFF);
        expect_now("neg_zlo", ID_ZL, 32'hFFFF_FFEC);
`else
        expect_now("neg_zhi", ID_ZH, 32'h0);
        expect_now("neg_zlo", ID_ZL, 32'h14);
`endif

        // Priority, wrap, idle bus
        c = '0; c.PCout = 1; c.R2out = 1; c.MARin = 1; step(c, 32'h0);
        expect_now("prio_mar", ID_MAR, 32'h1);
        c = '0; c.Read = 1; c.MDRin = 1; step(c, 32'hFFFF_FFFF);
        c = '0; c.MDRout = 1; c.PCin = 1; step(c, 32'h0);
        expect_now("pc_max", ID_PC, 32'hFFFF_FFFF);
        c = '0; c.IncPC = 1; step(c, 32'h0);
        expect_now("pc_wrap", ID_PC, 32'h0);
        c = '0; c.R1in = 1; step(c, 32'h0);
        expect_now("idle_r1", ID_R1, 32'h0);

        // Asynchronous clear mid-sequence, away from any clock edge
        c = '0; c.Read = 1; c.MDRin = 1; c.IncPC = 1; step(c, 32'hA5A5_0001);
        drive('0, 32'h0);
        #2;
        clear = 1'b0;
        #1;
        sb.delete();
        check_all_reset("async");
        @(posedge Clock);
        #1;
        check_all_reset("held");
        #2;
        clear = 1'b1;
        model_reset();
        @(posedge Clock);
        #1;

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            rb = 20'($urandom() & $urandom());
            c  = rb;
            step(c, $urandom());
        end

        @(negedge Clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
